// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes four BCD digits onto a common-anode 4-digit 7-segment
// display. Digits are snapshotted once per frame (no tearing), each slot
// starts with a short all-anodes-off guard (anti-ghost), and the digit
// picked by sel blinks while adjust mode is active.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 4,
  parameter int FLASH_DIV = 25000000,
  parameter int DP_SLOT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_1_val,
  input  logic [3:0] min_0_val,
  input  logic [3:0] sec_1_val,
  input  logic [3:0] sec_0_val,
  input  logic       adj,
  input  logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0]  GUARD_END  = SCAN_W'(GUARD);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);
  localparam logic [1:0]         DP_IDX     = 2'(DP_SLOT);

  // BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Active-low one-cold anode pattern for a slot index
  function automatic logic [3:0] slot_anode(input logic [1:0] s);
    logic [3:0] a;
    a    = 4'b1111;
    a[s] = 1'b0;
    return a;
  endfunction

  // ---- stage p0: scan/flash timing and digit snapshot ----
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         slot;
  logic [FLASH_W-1:0] flash_cnt;
  logic               flash_phase;
  logic [3:0]         shadow [4];

  logic               scan_wrap;
  logic               frame_load;
  logic [3:0]         cur_digit;
  logic               guard_blank;
  logic               flash_blank;

  assign scan_wrap   = (scan_cnt == SCAN_LAST);
  // Reset wins over a snapshot falling on the same edge, so the pulse is
  // suppressed too and always coincides with a real load.
  assign frame_load  = scan_wrap && (slot == 2'd3) && !rst;
  assign frame_tick  = frame_load;
  assign guard_blank = (scan_cnt < GUARD_END);
  assign flash_blank = adj && (slot == sel) && flash_phase;

  // Slot counter: scan_cnt wraps every SCAN_DIV cycles and advances the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      slot     <= 2'd0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      slot     <= slot + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Shadow digits load only at the frame boundary so a frame is never torn
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow[0] <= 4'd0;
      shadow[1] <= 4'd0;
      shadow[2] <= 4'd0;
      shadow[3] <= 4'd0;
    end else if (frame_load) begin
      shadow[0] <= sec_0_val;
      shadow[1] <= sec_1_val;
      shadow[2] <= min_0_val;
      shadow[3] <= min_1_val;
    end
  end

  // Blink timer runs only in adjust mode and restarts in the visible phase
  always_ff @(posedge clk) begin
    if (rst || !adj) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (flash_cnt == FLASH_LAST) begin
      flash_cnt   <= '0;
      flash_phase <= ~flash_phase;
    end else begin
      flash_cnt   <= flash_cnt + FLASH_W'(1);
    end
  end

  // Select the shadow digit belonging to the slot being scanned
  always_comb begin
    cur_digit = shadow[0];
    case (slot)
      2'd0: cur_digit = shadow[0];
      2'd1: cur_digit = shadow[1];
      2'd2: cur_digit = shadow[2];
      2'd3: cur_digit = shadow[3];
      default: cur_digit = shadow[0];
    endcase
  end

  // ---- stage p1: registered display drive ----
  logic [3:0] an_p1;
  logic [6:0] seg_p1;
  logic       dp_p1;

  // Cathodes follow the digit regardless of blanking; only anodes blank
  always_ff @(posedge clk) begin
    if (rst) begin
      an_p1  <= 4'b1111;
      seg_p1 <= 7'b1111111;
      dp_p1  <= 1'b1;
    end else begin
      an_p1  <= (guard_blank || flash_blank) ? 4'b1111 : slot_anode(slot);
      seg_p1 <= bcd_to_seg(cur_digit);
      dp_p1  <= (slot == DP_IDX) ? 1'b0 : 1'b1;
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;
  assign dp  = dp_p1;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Display-side consumer of the stopwatch digit counters.
- Takes four BCD digits (min_1, min_0, sec_1, sec_0) plus the adjust-mode select.
- Time-multiplexes them onto a common-anode 4-digit 7-segment display, with per-digit anti-ghost blanking.
- Flashes the digit chosen by sel while adjust mode is active, and snapshots the digits once per frame so there is no tearing.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (100 MHz gives a 2 kHz slot rate and a 500 Hz frame rate).
- GUARD, 4: cycles at the start of each slot with all anodes off (anti-ghost); must be less than SCAN_DIV.
- FLASH_DIV, 25000000: clk cycles per flash half-period (100 MHz gives a 2 Hz blink).
- DP_SLOT, 2: slot whose decimal point is lit, used as the minutes/seconds separator.

Ports:
- clk  in  1  board clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- min_1_val  in  4  BCD, tens of minutes.
- min_0_val  in  4  BCD, units of minutes.
- sec_1_val  in  4  BCD, tens of seconds.
- sec_0_val  in  4  BCD, units of seconds.
- adj  in  1  adjust mode active; enables flashing.
- sel  in  2  digit being adjusted: 00 = sec_0, 01 = sec_1, 10 = min_0, 11 = min_1.
- an  out  4  anode enables, active-low; an[0] = sec_0 ... an[3] = min_1.
- seg  out  7  cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse when the digit snapshot loads.

Behaviour:
- Clock and reset: single clock domain; rst is sampled only on the clk rising edge.
- Reset values (in the cycle after rst is sampled high):
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_tick = 0.
  - Internal: scan_cnt = 0, slot = 0, flash_cnt = 0, flash_phase = 0, shadow digits all 0.
- Reset mid-frame aborts the scan immediately. Scanning resumes from slot 0 with scan_cnt = 0 on the first cycle after rst deasserts.
- Scan counter:
  - scan_cnt counts 0 to SCAN_DIV-1 and wraps.
  - On wrap, slot advances 0→1→2→3→0.
- Snapshot:
  - On the wrap where slot goes 3→0, all four inputs are captured into the shadow register.
  - frame_tick = 1 in that same cycle, else 0.
  - Input changes at any other time have no visible effect until the next snapshot.
- Registered outputs: an, seg and dp are registered. The values at cycle t+1 reflect slot, scan_cnt and shadow at cycle t (one-cycle latency).
- Anode select: an = ~(1 << slot), except an = 4'b1111 whenever either condition holds:
  - scan_cnt < GUARD (guard blanking); or
  - adj = 1, slot == sel and flash_phase = 1 (flash blanking).
- Segment decode: seg is driven from the shadow digit of the current slot, irrespective of blanking.
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Any value 10–15 shows a dash, 0111111.
- Decimal point: dp = 0 when slot == DP_SLOT, else 1. It is masked only by an.
- Flash timer:
  - While adj = 0, flash_cnt and flash_phase are held at 0.
  - While adj = 1, flash_cnt counts 0 to FLASH_DIV-1; on wrap, flash_phase toggles.
  - On adj rising, the first FLASH_DIV cycles are therefore visible.
  - On adj falling, flashing stops on the next cycle and the digit reappears at the following output update.
- sel changes take effect at the next registered output update; flash_phase is not reset by a sel change.
- Width rules:
  - scan_cnt is $clog2(SCAN_DIV) bits and flash_cnt is $clog2(FLASH_DIV) bits.
  - slot is 2 bits and wraps naturally.
- Invariant: at most one anode is low in any cycle.

Test Plan (bench overrides: SCAN_DIV = 8, GUARD = 2, FLASH_DIV = 64, DP_SLOT = 2):
- Reset sequence: hold rst for 3 cycles, then release → an = 1111, seg = 1111111, dp = 1 during reset. First an = 1110 appears 3 cycles after release (scan_cnt = 2 at t, output at t+1). Shadow is 0, so seg = 1000000.
- Digit decode: inputs 1,2,3,4 (min_1..sec_0) held through one frame → after frame_tick, the next frame shows an = 1110/seg = 0011001, 1101/0110000, 1011/0100100 with dp = 0, then 0111/1111001. Each slot has 6 visible cycles after 2 blank cycles.
- Tearing: change sec_0_val from 4 to 7 mid-frame at slot 1 → slot 0 keeps showing 4 until the next frame_tick, then shows 1111000. Input 12 on any digit → seg = 0111111.
- Flash: adj = 1, sel = 10 → slot 2 visible for the first 64 cycles, anodes blanked in slot 2 for the next 64, then repeating. Slots 0, 1 and 3 are unaffected. Drop adj during a blank phase → slot 2 visible on its next occurrence.
- Reset mid-operation: assert rst at slot 3, scan_cnt = 5, with adj = 1 and flash_phase = 1 → outputs return to reset values next cycle. After release, scanning restarts at slot 0, the shadow reads 0 until the next frame_tick, and flashing is visible for 64 cycles.
- Invariant check: a random input/adj/sel soak of at least 10000 cycles → never more than one an bit low, and frame_tick exactly once per 32 cycles.
